// File: rtl/pc_fetch_unit.sv
// Program-counter fetch stage: issues instruction-memory requests, registers fetched words, redirects on branches.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        branchtaken_in,
  input  logic [31:0] target_in,
  input  logic        stall_in,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_rdata_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out,
  output logic        misalign_out,
  output logic [1:0]  state_dbg_out
);

  // Handshake: a fetch completes on a rising edge where imem_req_out=1 and
  // imem_ready_in=1; imem_addr_out stays stable until that edge.

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    flush_d      = 1'b0;
    misalign_d   = misalign_q;
    imem_req_out = 1'b0;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH, S_HOLD: begin
        imem_req_out = (state_q == S_FETCH) && !stall_in;
        if (branchtaken_in) begin
          // Redirect beats stall and ready; the word returned this cycle is dropped.
          valid_d = 1'b0;
          flush_d = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
          if (target_in[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d    = target_in;
            state_d = S_FETCH;
          end
`else
          pc_d    = target_in & 32'hFFFF_FFFC;
          state_d = S_FETCH;
`endif
        end else if (stall_in) begin
          state_d = S_HOLD;
        end else if (state_q == S_HOLD) begin
          state_d = S_FETCH;
        end else if (imem_ready_in) begin
          instr_d  = imem_rdata_in;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 32'd4;
        end else begin
          valid_d = 1'b0;
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_RST;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      pc_out_q   <= 32'h0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr_out   = pc_q;
  assign instr_out       = instr_q;
  assign pc_out          = pc_out_q;
  assign instr_valid_out = valid_q;
  assign flush_out       = flush_q;
  assign state_dbg_out   = state_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_out    = misalign_q;
`else
  assign misalign_out    = 1'b0;
`endif

endmodule
